mprj_wb_mailbox: RTL

User-project Wishbone slave that sits directly downstream of the management core's exported `mprj_*` Wishbone bus. It gives the CPU a word-wide mailbox into user logic: a TX FIFO that the CPU pushes and user logic drains, and an RX FIFO that user logic fills and the CPU drains. The block also has a status register and a level interrupt, which is routed to one bit of the management core's `irq` input.

---
 rtl/mprj_wb_mailbox.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mprj_wb_mailbox.sv
// mprj_wb_mailbox: Wishbone slave giving the mgmt CPU a word-wide
// mailbox into user logic. The CPU pushes a TX FIFO that user logic
// drains, and user logic fills an RX FIFO that the CPU drains.
// Ports:
//   wb_clk_i, wb_rst_i : clock, async active-high reset
//   wbs_*              : Wishbone slave (cyc/stb/we/sel/adr/dat/ack)
//   tx_data/valid/ready: TX FIFO head toward user logic
//   rx_data/valid/ready: RX FIFO push port from user logic
//   irq_o              : registered level interrupt
// Registers (byte offset): 0x0 TXDATA, 0x4 RXDATA,
//   0x8 STATUS, 0xC IRQEN.
module mprj_wb_mailbox #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [31:0] ADR_MASK = 32'hFFFF_FFF0,
  parameter int          DEPTH    = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] OFF_TX = 2'd0;
  localparam logic [1:0] OFF_RX = 2'd1;
  localparam logic [1:0] OFF_ST = 2'd2;
  localparam logic [1:0] OFF_IE = 2'd3;

  logic          ack_q;
  logic          ack_d;
  logic [31:0]   dat_q;
  logic [31:0]   dat_d;

  logic [PW-1:0] tx_wp_q;
  logic [PW-1:0] tx_wp_d;
  logic [PW-1:0] tx_rp_q;
  logic [PW-1:0] tx_rp_d;
  logic [CW-1:0] tx_cnt_q;
  logic [CW-1:0] tx_cnt_d;

  logic [PW-1:0] rx_wp_q;
  logic [PW-1:0] rx_wp_d;
  logic [PW-1:0] rx_rp_q;
  logic [PW-1:0] rx_rp_d;
  logic [CW-1:0] rx_cnt_q;
  logic [CW-1:0] rx_cnt_d;

  logic          tx_ovf_q;
  logic          tx_ovf_d;
  logic          rx_unf_q;
  logic          rx_unf_d;
  logic [1:0]    irqen_q;
  logic [1:0]    irqen_d;
  logic          irq_q;
  logic          irq_d;

  logic [31:0]   tx_mem_q [DEPTH];
  logic [31:0]   tx_mem_d [DEPTH];
  logic [31:0]   rx_mem_q [DEPTH];
  logic [31:0]   rx_mem_d [DEPTH];

  logic          hit;
  logic          req;
  logic          wr;
  logic          rd;
  logic [1:0]    off;

  logic          tx_full;
  logic          tx_empty;
  logic          rx_full;
  logic          rx_empty;

  logic          tx_push;
  logic          tx_pop;
  logic          tx_ovf_set;
  logic          rx_push;
  logic          rx_rd;
  logic          rx_pop;
  logic          rx_unf_set;
  logic          st_wr;
  logic          ie_wr;

  logic [3:0]    tx_cnt4;
  logic [3:0]    rx_cnt4;
  logic [31:0]   status;

  logic          unused_ok;

  assign unused_ok = ^wbs_sel_i[2:1];

  assign hit = (wbs_adr_i & ADR_MASK) == BASE_ADR;
  assign req = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign off = wbs_adr_i[3:2];
  assign wr  = req & wbs_we_i;
  assign rd  = req & ~wbs_we_i;

  assign tx_full  = tx_cnt_q == FULL_CNT;
  assign tx_empty = tx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == FULL_CNT;
  assign rx_empty = rx_cnt_q == '0;

  // Fullness is the pre-edge view: a same-cycle
  // user pop does not make room for a CPU push.
  assign tx_push    = wr & (off == OFF_TX) & ~tx_full;
  assign tx_ovf_set = wr & (off == OFF_TX) & tx_full;
  assign tx_pop     = ~tx_empty & tx_ready;

  // An RXDATA read on an empty FIFO underflows even
  // if user logic pushes in the same cycle.
  assign rx_push    = rx_valid & ~rx_full;
  assign rx_rd      = rd & (off == OFF_RX);
  assign rx_pop     = rx_rd & ~rx_empty;
  assign rx_unf_set = rx_rd & rx_empty;

  assign st_wr = wr & (off == OFF_ST) & wbs_sel_i[3];
  assign ie_wr = wr & (off == OFF_IE) & wbs_sel_i[0];

  assign tx_cnt4 = 4'(tx_cnt_q);
  assign rx_cnt4 = 4'(rx_cnt_q);

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[11:8]  = tx_cnt4;
    status[19:16] = rx_cnt4;
    status[24]    = tx_ovf_q;
    status[25]    = rx_unf_q;
  end

  always_comb begin
    ack_d = req;
    dat_d = '0;
    if (rd) begin
      unique case (off)
        OFF_TX: dat_d = '0;
        OFF_RX: begin
          if (!rx_empty) begin
            dat_d = rx_mem_q[rx_rp_q];
          end
        end
        OFF_ST: dat_d = status;
        OFF_IE: dat_d = {30'd0, irqen_q};
        default: dat_d = '0;
      endcase
    end
  end

  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    if (tx_push) begin
      tx_mem_d[tx_wp_q] = wbs_dat_i;
      tx_wp_d = tx_wp_q + PW'(1);
    end
    if (tx_pop) begin
      tx_rp_d = tx_rp_q + PW'(1);
    end
    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_comb begin
    rx_mem_d = rx_mem_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    if (rx_push) begin
      rx_mem_d[rx_wp_q] = rx_data;
      rx_wp_d = rx_wp_q + PW'(1);
    end
    if (rx_pop) begin
      rx_rp_d = rx_rp_q + PW'(1);
    end
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // Clear first, then set, so a new event wins
  // over a same-cycle clear.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (st_wr && wbs_dat_i[24]) begin
      tx_ovf_d = 1'b0;
    end
    if (st_wr && wbs_dat_i[25]) begin
      rx_unf_d = 1'b0;
    end
    if (tx_ovf_set) begin
      tx_ovf_d = 1'b1;
    end
    if (rx_unf_set) begin
      rx_unf_d = 1'b1;
    end
  end

  always_comb begin
    irqen_d = irqen_q;
    if (ie_wr) begin
      irqen_d = wbs_dat_i[1:0];
    end
    irq_d = (irqen_q[0] & ~rx_empty)
          | (irqen_q[1] & tx_empty);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
      irqen_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
      irqen_q  <= irqen_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset; occupancy lives in
  // the counters and pointers.
  always_ff @(posedge wb_clk_i) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign tx_data   = tx_mem_q[tx_rp_q];
  assign tx_valid  = ~tx_empty;
  assign rx_ready  = ~rx_full;
  assign irq_o     = irq_q;

endmodule
